// File: rtl/fxp_pkg.sv
// Shared constants, ALU opcodes, flag indices and sequencer state type for the
// fixed-point (Q7.8 sign-magnitude) datapath.
package fxp_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_MUL = 3'b010;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_C = 0;

  localparam logic [15:0] FXP_ZERO     = 16'h0000;
  localparam logic [15:0] FXP_NEG_ZERO = 16'h8000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_MUL,
    S_ACC,
    S_DONE
  } seq_state_t;

  // Negative zero folds to positive zero so stored values have one zero encoding.
  function automatic logic [15:0] fxp_norm(input logic [15:0] x);
    return (x == FXP_NEG_ZERO) ? FXP_ZERO : x;
  endfunction

endpackage

// File: rtl/fxp_dot_sequencer_alu.sv
// Combinational Q7.8 sign-magnitude ALU: ADD (magnitude wraps, carry to C) and
// MUL (magnitude bits [8:0] only, product >> 8). Flags are NZVC.
module fixedpointAlu
  import fxp_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [2:0]  ctrl,
  output logic [15:0] result,
  output logic [3:0]  flags
);

  logic        sa;
  logic        sb;
  logic [14:0] ma;
  logic [14:0] mb;
  logic [15:0] mag_sum;

  always_comb begin
    sa      = a[15];
    sb      = b[15];
    ma      = a[14:0];
    mb      = b[14:0];
    mag_sum = {1'b0, ma} + {1'b0, mb};
    result  = '0;
    flags   = '0;
    if (ctrl == ALU_MUL) begin
      result = {sa ^ sb, 5'b0, 10'(({9'b0, a[8:0]} * {9'b0, b[8:0]}) >> 8)};
    end else if (sa == sb) begin
      result        = {sa, mag_sum[14:0]};
      flags[FLAG_C] = mag_sum[15];
      flags[FLAG_V] = mag_sum[15];
    end else if (ma > mb) begin
      result = {sa, ma - mb};
    end else begin
      // Equal magnitudes take b's sign, so +x + -x yields negative zero.
      result = {sb, mb - ma};
    end
    flags[FLAG_N] = result[15];
    flags[FLAG_Z] = (result[14:0] == '0);
  end

endmodule

// File: rtl/fxp_dot_sequencer.sv
// Sequences one shared fixedpointAlu to form a Q7.8 sign-magnitude dot product
// over two operand memories, four cycles per element, with sticky overflow.
module fxp_dot_sequencer
  import fxp_pkg::*;
#(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_a_addr,
  output logic [ADDR_W-1:0] mem_b_addr,
  input  logic [15:0]       mem_a_data,
  input  logic [15:0]       mem_b_data,
  output logic              busy,
  output logic              done,
  output logic [15:0]       result,
  output logic              ovf
);

  localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

  seq_state_t        state;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   idx;
  logic [ADDR_W:0]   idx_next;
  logic [ADDR_W-1:0] base_a_q;
  logic [ADDR_W-1:0] base_b_q;
  logic [15:0]       op_a;
  logic [15:0]       op_b;
  logic [15:0]       prod;
  logic [15:0]       acc;

  logic [2:0]        alu_ctrl;
  logic [15:0]       alu_a;
  logic [15:0]       alu_b;
  logic [15:0]       alu_result;
  logic [3:0]        alu_flags;

  assign idx_next = idx + 1'b1;

  // Outside MUL/ACC the ALU sees ADD 0+0 so its outputs stay static.
  always_comb begin
    alu_ctrl = ALU_ADD;
    alu_a    = '0;
    alu_b    = '0;
    case (state)
      S_MUL: begin
        alu_ctrl = ALU_MUL;
        alu_a    = op_a;
        alu_b    = op_b;
      end
      S_ACC: begin
        alu_a = acc;
        alu_b = prod;
      end
      default: ;
    endcase
  end

  fixedpointAlu alu (
    .a      (alu_a),
    .b      (alu_b),
    .ctrl   (alu_ctrl),
    .result (alu_result),
    .flags  (alu_flags)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      len_q      <= '0;
      idx        <= '0;
      base_a_q   <= '0;
      base_b_q   <= '0;
      op_a       <= '0;
      op_b       <= '0;
      prod       <= '0;
      acc        <= '0;
      mem_rd_en  <= 1'b0;
      mem_a_addr <= '0;
      mem_b_addr <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      ovf        <= 1'b0;
    end else begin
      mem_rd_en <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            acc  <= '0;
            ovf  <= 1'b0;
            busy <= 1'b1;
            if (len == '0) begin
              state  <= S_DONE;
              done   <= 1'b1;
              result <= FXP_ZERO;
            end else begin
              state      <= S_READ;
              len_q      <= (len > LEN_MAX) ? LEN_MAX : len;
              base_a_q   <= base_a;
              base_b_q   <= base_b;
              idx        <= '0;
              mem_rd_en  <= 1'b1;
              mem_a_addr <= base_a;
              mem_b_addr <= base_b;
            end
          end
        end
        S_READ: state <= S_WAIT;
        S_WAIT: begin
          op_a  <= mem_a_data;
          op_b  <= mem_b_data;
          state <= S_MUL;
        end
        S_MUL: begin
          prod  <= fxp_norm(alu_result);
          state <= S_ACC;
        end
        S_ACC: begin
          acc <= fxp_norm(alu_result);
          ovf <= ovf | alu_flags[FLAG_C];
          idx <= idx_next;
          if (idx == len_q - 1'b1) begin
            state  <= S_DONE;
            done   <= 1'b1;
            result <= fxp_norm(alu_result);
          end else begin
            state      <= S_READ;
            mem_rd_en  <= 1'b1;
            mem_a_addr <= base_a_q + idx_next[ADDR_W-1:0];
            mem_b_addr <= base_b_q + idx_next[ADDR_W-1:0];
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fxp_dot_sequencer.sv
// Scoreboard bench for fxp_dot_sequencer: directed cases plus random vectors
// checked against an integer-arithmetic reference model.
module tb_fxp_dot_sequencer;

  localparam int unsigned AW    = 6;
  localparam int unsigned DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   len_in;
  logic [AW-1:0] base_a_in;
  logic [AW-1:0] base_b_in;
  logic          mem_rd_en;
  logic [AW-1:0] mem_a_addr;
  logic [AW-1:0] mem_b_addr;
  logic [15:0]   mem_a_data;
  logic [15:0]   mem_b_data;
  logic          busy;
  logic          done;
  logic [15:0]   result;
  logic          ovf;

  fxp_dot_sequencer #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len_in),
    .base_a     (base_a_in),
    .base_b     (base_b_in),
    .mem_rd_en  (mem_rd_en),
    .mem_a_addr (mem_a_addr),
    .mem_b_addr (mem_b_addr),
    .mem_a_data (mem_a_data),
    .mem_b_data (mem_b_data),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  logic [15:0] mem_a [DEPTH];
  logic [15:0] mem_b [DEPTH];

  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_a_data <= mem_a[mem_a_addr];
      mem_b_data <= mem_b[mem_b_addr];
    end
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] res;
    logic        ovf;
    int unsigned at;
  } exp_t;

  exp_t        exp_q[$];
  logic [11:0] addr_q[$];
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference arithmetic on signed integers, rebuilt into sign-magnitude.
  function automatic logic [15:0] m_mul(input logic [15:0] x, input logic [15:0] y);
    int m;
    m = (int'(x[8:0]) * int'(y[8:0])) / 256;
    if (m == 0) return 16'h0000;
    return {x[15] ^ y[15], 15'(m)};
  endfunction

  function automatic logic [16:0] m_add(input logic [15:0] x, input logic [15:0] y);
    int va, vb, s, am;
    logic c;
    logic [15:0] r;
    va = x[15] ? -int'(x[14:0]) : int'(x[14:0]);
    vb = y[15] ? -int'(y[14:0]) : int'(y[14:0]);
    s  = va + vb;
    am = (s < 0) ? -s : s;
    c  = (am >= 32768);
    am = am % 32768;
    r  = (am == 0) ? 16'h0000 : {(s < 0) ? 1'b1 : 1'b0, 15'(am)};
    return {c, r};
  endfunction

  task automatic model_dot(input int unsigned l, input int unsigned ba, input int unsigned bb,
                           output logic [15:0] r, output logic o);
    logic [16:0] s;
    r = 16'h0000;
    o = 1'b0;
    for (int unsigned i = 0; i < l; i++) begin
      s = m_add(r, m_mul(mem_a[(ba + i) % DEPTH], mem_b[(bb + i) % DEPTH]));
      r = s[15:0];
      o = o | s[16];
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    check("wait_idle_timeout", 32'(busy), 0);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = 16'h0000;
      mem_b[i] = 16'h0000;
    end
  endtask

  task automatic launch(input int unsigned len, input int unsigned ba, input int unsigned bb,
                        input bit use_const, input logic [15:0] cres, input logic cov);
    int unsigned l;
    logic [15:0] r;
    logic        o;
    exp_t        e;
    wait_idle();
    l = (len > DEPTH) ? DEPTH : len;
    model_dot(l, ba, bb, r, o);
    if (use_const) begin
      r = cres;
      o = cov;
    end
    for (int unsigned i = 0; i < l; i++)
      addr_q.push_back({6'((ba + i) % DEPTH), 6'((bb + i) % DEPTH)});
    len_in    = 7'(len);
    base_a_in = 6'(ba);
    base_b_in = 6'(bb);
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.res = r;
    e.ovf = o;
    e.at  = cyc + 4 * l;
    exp_q.push_back(e);
    check("busy_after_start", 32'(busy), 1);
  endtask

  // Monitor: every read strobe and every done pulse must match a queued expectation.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (mem_rd_en) begin
        if (addr_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rd_en: got rd_en=1 at a=%0d expected no read", mem_a_addr);
        end else begin
          logic [11:0] ea;
          ea = addr_q.pop_front();
          check("addr_a", 32'(mem_a_addr), 32'(ea[11:6]));
          check("addr_b", 32'(mem_b_addr), 32'(ea[5:0]));
        end
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done=1 result=%h expected no done", result);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("result", 32'(result), 32'(e.res));
          check("ovf", 32'(ovf), 32'(e.ovf));
          check("done_cycle", cyc, e.at);
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    len_in    = '0;
    base_a_in = '0;
    base_b_in = '0;
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_rd_en", 32'(mem_rd_en), 0);
    check("rst_addr_a", 32'(mem_a_addr), 0);
    check("rst_addr_b", 32'(mem_b_addr), 0);
    check("rst_result", 32'(result), 0);
    check("rst_ovf", 32'(ovf), 0);
    @(negedge clk);
    rst = 1'b0;

    // T1
    clear_mem();
    mem_a[0] = 16'h0100; mem_a[1] = 16'h0080;
    mem_b[0] = 16'h0180; mem_b[1] = 16'h0100;
    launch(2, 0, 0, 1, 16'h0200, 1'b0);
    // T2
    wait_idle();
    mem_a[0] = 16'h8100; mem_a[1] = 16'h0100;
    mem_b[0] = 16'h0100; mem_b[1] = 16'h0080;
    launch(2, 0, 0, 1, 16'h8080, 1'b0);
    // T3
    launch(0, 5, 9, 1, 16'h0000, 1'b0);
    // T5
    wait_idle();
    mem_a[0] = 16'h0100; mem_a[1] = 16'h8100;
    mem_b[0] = 16'h0100; mem_b[1] = 16'h0100;
    launch(2, 0, 0, 1, 16'h0000, 1'b0);
    // T4
    wait_idle();
    for (int i = 0; i < 33; i++) begin
      mem_a[i] = 16'h01FF;
      mem_b[i] = 16'h01FF;
    end
    launch(33, 0, 0, 1, 16'h037C, 1'b1);

    // T6a: wrapped addresses; start while busy and in the DONE cycle are ignored
    wait_idle();
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = 16'($urandom);
      mem_b[i] = 16'($urandom);
    end
    launch(4, 62, 10, 0, 16'h0000, 1'b0);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) break;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // T6b: reset at edge 5 aborts with no done
    wait_idle();
    addr_q.push_back({6'd62, 6'd10});
    addr_q.push_back({6'd63, 6'd11});
    len_in    = 7'd4;
    base_a_in = 6'd62;
    base_b_in = 6'd10;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_result", 32'(result), 0);
    check("abort_ovf", 32'(ovf), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);

    // Random vectors, including lengths above the clamp point
    for (int n = 0; n < 25; n++) begin
      int unsigned l;
      wait_idle();
      for (int i = 0; i < DEPTH; i++) begin
        mem_a[i] = 16'($urandom);
        mem_b[i] = 16'($urandom);
      end
      l = ($urandom_range(0, 4) == 0) ? $urandom_range(65, 127) : $urandom_range(1, 64);
      launch(l, $urandom_range(0, 63), $urandom_range(0, 63), 0, 16'h0000, 1'b0);
    end

    wait_idle();
    repeat (5) @(negedge clk);
    check("pending_reads", 32'(addr_q.size()), 0);
    check("pending_dones", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
